prog_line_filler: RTL and testbench

Memory-side responder for the program cache's line-refill protocol. Accepts a miss request (top address plus line index), fetches the 64-byte line from backing memory as sixteen 32-bit reads, and assembles it into a 512-bit line. It then queues the line with its index in a small FIFO that the program cache drains. It sits between the program cache and the memory/bus interface, single clock domain.

---
 rtl/prog_fill_pkg.sv | 30 +++
 rtl/line_fifo.sv | 86 ++++++++
 rtl/prog_line_filler.sv | 133 +++++++++++++
 tb/tb_prog_line_filler.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_fill_pkg.sv
// Shared types and constants for the program-cache line refill responder.
package prog_fill_pkg;

    localparam int LINE_WIDTH     = 512;
    localparam int WORD_WIDTH     = 32;
    localparam int TOP_ADDR_WIDTH = 18;
    localparam int INDEX_WIDTH    = 8;
    localparam int WORDS_PER_LINE = 16;
    localparam int WORD_CNT_WIDTH = 4;
    localparam int FIFO_WIDTH     = INDEX_WIDTH + LINE_WIDTH;

    localparam logic [WORD_CNT_WIDTH-1:0] LAST_WORD = WORD_CNT_WIDTH'(WORDS_PER_LINE - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        PUSH  = 2'd3
    } fill_state_t;

    // Byte address of one word of a line: {tag, index, word, 2'b00}.
    function automatic logic [31:0] word_byte_addr(
        input logic [TOP_ADDR_WIDTH-1:0] tag,
        input logic [INDEX_WIDTH-1:0]    index,
        input logic [WORD_CNT_WIDTH-1:0] word
    );
        return {tag, index, word, 2'b00};
    endfunction

endpackage

// File: rtl/line_fifo.sv
// Synchronous show-ahead FIFO; flags and head entry are registered.
module line_fifo #(
    parameter int WIDTH = 520,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r, wr_ptr_s, rd_ptr_s;
    logic [CNT_W-1:0] count_r, count_s;
    logic             do_push_s, do_pop_s;
    logic [WIDTH-1:0] head_s, head_r;
    logic             full_r, empty_r;

    // Next pointer/count values; a pop on an empty FIFO is dropped.
    always_comb begin
        do_pop_s  = pop && (count_r != CNT_W'(0));
        do_push_s = push && ((count_r != FULL_COUNT) || do_pop_s);
        wr_ptr_s  = wr_ptr_r;
        rd_ptr_s  = rd_ptr_r;
        count_s   = count_r;
        if (do_push_s) begin
            wr_ptr_s = wr_ptr_r + PTR_W'(1);
        end else begin
            wr_ptr_s = wr_ptr_r;
        end
        if (do_pop_s) begin
            rd_ptr_s = rd_ptr_r + PTR_W'(1);
        end else begin
            rd_ptr_s = rd_ptr_r;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_s = count_r + CNT_W'(1);
            2'b01:   count_s = count_r - CNT_W'(1);
            default: count_s = count_r;
        endcase
        // The entry being written lands at the new head when the FIFO holds only it.
        if (do_push_s && (wr_ptr_r == rd_ptr_s)) begin
            head_s = push_data;
        end else begin
            head_s = mem_r[rd_ptr_s];
        end
    end

    // Pointer, occupancy and flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            wr_ptr_r <= wr_ptr_s;
            rd_ptr_r <= rd_ptr_s;
            count_r  <= count_s;
            full_r   <= (count_s == FULL_COUNT);
            empty_r  <= (count_s == CNT_W'(0));
        end
    end

    // Storage and head register carry no reset; contents are don't-care when empty.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
        head_r <= head_s;
    end

    assign full  = full_r;
    assign empty = empty_r;
    assign head  = head_r;

endmodule

// File: rtl/prog_line_filler.sv
// Line refill responder: fetches sixteen 32-bit words, assembles a 512-bit line, queues it.
module prog_line_filler
    import prog_fill_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      is_req,
    input  logic [TOP_ADDR_WIDTH-1:0] req_addr,
    input  logic [INDEX_WIDTH-1:0]    req_index,
    output logic                      req_ack,
    output logic                      busy,
    output logic                      mem_rd_en,
    output logic [31:0]               mem_addr,
    input  logic                      mem_rd_valid,
    input  logic [WORD_WIDTH-1:0]     mem_rd_data,
    input  logic                      fifo_pop,
    output logic                      fifo_empty,
    output logic                      fifo_full,
    output logic [INDEX_WIDTH-1:0]    fifo_addr,
    output logic [LINE_WIDTH-1:0]     read_line_data
);

    fill_state_t                                 state_r, state_s;
    logic [TOP_ADDR_WIDTH-1:0]                   tag_r, tag_s;
    logic [INDEX_WIDTH-1:0]                      index_r, index_s;
    logic [WORD_CNT_WIDTH-1:0]                   word_cnt_r, word_cnt_s;
    logic [WORDS_PER_LINE-1:0][WORD_WIDTH-1:0]   line_r;
    logic                                        accept_s, line_wr_s, push_s;
    logic                                        req_ack_r, busy_r, mem_rd_en_r;
    logic [31:0]                                 mem_addr_r;
    logic [FIFO_WIDTH-1:0]                       head_s;

    // Fill sequencer next-state logic.
    always_comb begin
        state_s    = state_r;
        tag_s      = tag_r;
        index_s    = index_r;
        word_cnt_s = word_cnt_r;
        accept_s   = 1'b0;
        line_wr_s  = 1'b0;
        push_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (is_req) begin
                    accept_s   = 1'b1;
                    tag_s      = req_addr;
                    index_s    = req_index;
                    word_cnt_s = '0;
                    state_s    = FETCH;
                end else begin
                    state_s = IDLE;
                end
            end
            FETCH: state_s = WAIT;
            WAIT: begin
                if (mem_rd_valid) begin
                    line_wr_s = 1'b1;
                    if (word_cnt_r == LAST_WORD) begin
                        state_s = PUSH;
                    end else begin
                        word_cnt_s = word_cnt_r + WORD_CNT_WIDTH'(1);
                        state_s    = FETCH;
                    end
                end else begin
                    state_s = WAIT;
                end
            end
            PUSH: begin
                // A same-cycle pop frees the slot even when the FIFO reads full.
                if (!fifo_full || fifo_pop) begin
                    push_s  = 1'b1;
                    state_s = IDLE;
                end else begin
                    state_s = PUSH;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Control state and registered outputs, decoded from next-state values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            word_cnt_r  <= '0;
            req_ack_r   <= 1'b0;
            busy_r      <= 1'b0;
            mem_rd_en_r <= 1'b0;
            mem_addr_r  <= 32'd0;
        end else begin
            state_r     <= state_s;
            word_cnt_r  <= word_cnt_s;
            req_ack_r   <= accept_s;
            busy_r      <= (state_s != IDLE);
            mem_rd_en_r <= (state_s == FETCH);
            if (state_s == FETCH) begin
                mem_addr_r <= word_byte_addr(tag_s, index_s, word_cnt_s);
            end
        end
    end

    // Request latch and line assembly; the line buffer is never cleared.
    always_ff @(posedge clk) begin
        tag_r   <= tag_s;
        index_r <= index_s;
        if (line_wr_s && !reset) begin
            line_r[word_cnt_r] <= mem_rd_data;
        end
    end

    line_fifo #(
        .WIDTH (FIFO_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_line_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_s),
        .push_data ({index_r, line_r}),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (head_s)
    );

    assign {fifo_addr, read_line_data} = head_s;
    assign req_ack   = req_ack_r;
    assign busy      = busy_r;
    assign mem_rd_en = mem_rd_en_r;
    assign mem_addr  = mem_addr_r;

endmodule

// File: tb/tb_prog_line_filler.sv
// Directed bench for prog_line_filler with a memory responder and a line scoreboard.
module tb_prog_line_filler;

    logic         clk;
    logic         reset;
    logic         is_req;
    logic [17:0]  req_addr;
    logic [7:0]   req_index;
    logic         req_ack, busy, mem_rd_en;
    logic [31:0]  mem_addr;
    logic         mem_rd_valid;
    logic [31:0]  mem_rd_data;
    logic         fifo_pop, fifo_empty, fifo_full;
    logic [7:0]   fifo_addr;
    logic [511:0] read_line_data;

    prog_line_filler dut (
        .clk            (clk),
        .reset          (reset),
        .is_req         (is_req),
        .req_addr       (req_addr),
        .req_index      (req_index),
        .req_ack        (req_ack),
        .busy           (busy),
        .mem_rd_en      (mem_rd_en),
        .mem_addr       (mem_addr),
        .mem_rd_valid   (mem_rd_valid),
        .mem_rd_data    (mem_rd_data),
        .fifo_pop       (fifo_pop),
        .fifo_empty     (fifo_empty),
        .fifo_full      (fifo_full),
        .fifo_addr      (fifo_addr),
        .read_line_data (read_line_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int mem_wait = 0;
    logic [31:0] mem_seed = 32'd0;
    logic [519:0] sb[$];
    logic [31:0]  addr_q[$];
    int viol = 0;
    int ack_cnt = 0;

    // Word k of a line is seed + k for index 8'h45; other indices perturb bits [27:20].
    function automatic logic [31:0] mem_word(input logic [31:0] seed, input logic [31:0] a);
        return seed + {4'h0, a[13:6] ^ 8'h45, 16'h0000, a[5:2]};
    endfunction

    function automatic logic [511:0] build_line(input logic [17:0] t, input logic [7:0] ix,
                                                input logic [31:0] seed);
        logic [511:0] l;
        for (int k = 0; k < 16; k++) begin
            l[32*k +: 32] = mem_word(seed, {t, ix, 4'(k), 2'b00});
        end
        return l;
    endfunction

    // Memory model: answers each strobe after 1 + mem_wait cycles.
    initial begin
        int cd;
        logic [31:0] pend_addr;
        cd = 0;
        pend_addr = 32'd0;
        mem_rd_valid = 1'b0;
        mem_rd_data = 32'd0;
        forever begin
            @(negedge clk);
            mem_rd_valid = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    mem_rd_valid = 1'b1;
                    mem_rd_data  = mem_word(mem_seed, pend_addr);
                end
            end
            if (mem_rd_en === 1'b1) begin
                if (cd != 0) viol++;
                addr_q.push_back(mem_addr);
                pend_addr = mem_addr;
                cd = 1 + mem_wait;
            end
        end
    end

    always @(negedge clk) begin
        if (req_ack === 1'b1) ack_cnt <= ack_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [519:0] obs, input logic [519:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " idle-timeout"}, 520'(n < budget), 520'(1));
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge of cycle 1.
    task automatic start_fill(input string tag, input logic [17:0] t, input logic [7:0] ix,
                              input logic [31:0] seed, input int wt);
        mem_seed  = seed;
        mem_wait  = wt;
        req_addr  = t;
        req_index = ix;
        is_req    = 1'b1;
        sb.push_back({ix, build_line(t, ix, seed)});
        @(negedge clk);
        chk({tag, " ack"}, 520'(req_ack), 520'(1));
        is_req = 1'b0;
    endtask

    task automatic pop_check(input string tag);
        logic [519:0] e;
        chk({tag, " nonempty"}, 520'(fifo_empty), 520'(0));
        if (sb.size() == 0) begin
            chk({tag, " sb-underflow"}, 520'(0), 520'(1));
            e = '0;
        end else begin
            e = sb.pop_front();
        end
        chk({tag, " index"}, 520'(fifo_addr), 520'(e[519:512]));
        chk({tag, " line"}, 520'(read_line_data), 520'(e[511:0]));
        fifo_pop = 1'b1;
        @(negedge clk);
        fifo_pop = 1'b0;
    endtask

    initial begin
        int cyc;
        int base;
        int c0;
        reset = 1'b1;
        is_req = 1'b0;
        req_addr = 18'd0;
        req_index = 8'd0;
        fifo_pop = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst req_ack", 520'(req_ack), 520'(0));
        chk("rst busy", 520'(busy), 520'(0));
        chk("rst mem_rd_en", 520'(mem_rd_en), 520'(0));
        chk("rst mem_addr", 520'(mem_addr), 520'(0));
        chk("rst empty", 520'(fifo_empty), 520'(1));
        chk("rst full", 520'(fifo_full), 520'(0));

        // Single fill, zero-wait memory.
        base = addr_q.size();
        start_fill("t1", 18'h01234, 8'h45, 32'hA000_0000, 0);
        cyc = 1;
        chk("t1 busy", 520'(busy), 520'(1));
        chk("t1 rd_en", 520'(mem_rd_en), 520'(1));
        chk("t1 addr0", 520'(mem_addr), 520'(32'h048D_1140));
        @(negedge clk);
        cyc++;
        chk("t1 ack-pulse", 520'(req_ack), 520'(0));
        while (fifo_empty === 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("t1 latency", 520'(cyc), 520'(34));
        chk("t1 nreads", 520'(addr_q.size() - base), 520'(16));
        for (int k = 0; k < 16; k++) begin
            if (base + k < addr_q.size())
                chk($sformatf("t1 addr%0d", k), 520'(addr_q[base+k]), 520'(32'h048D_1140 + 32'(4*k)));
        end
        chk("t1 fifo_addr", 520'(fifo_addr), 520'(8'h45));
        chk("t1 word0", 520'(read_line_data[31:0]), 520'(32'hA000_0000));
        chk("t1 word15", 520'(read_line_data[511:480]), 520'(32'hA000_000F));
        chk("t1 busy-done", 520'(busy), 520'(0));
        pop_check("t1");
        chk("t1 drained", 520'(fifo_empty), 520'(1));

        // Three wait cycles per word, boundary tag/index.
        start_fill("t2", 18'h3FFFF, 8'hFF, 32'h1234_5678, 3);
        cyc = 1;
        chk("t2 addr0", 520'(mem_addr), 520'(32'hFFFF_FFC0));
        while (fifo_empty === 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("t2 latency", 520'(cyc), 520'(82));
        chk("t2 early-strobe", 520'(viol), 520'(0));
        pop_check("t2");

        // Fill the FIFO, then stall the fifth fill in PUSH.
        for (int i = 0; i < 4; i++) begin
            start_fill($sformatf("t3 f%0d", i), 18'h00100 + 18'(i), 8'h10 + 8'(i),
                       32'h0100_0000 * 32'(i + 1), 0);
            wait_idle($sformatf("t3 f%0d", i), 100);
            chk($sformatf("t3 full%0d", i), 520'(fifo_full), 520'(i == 3));
        end
        start_fill("t3 f4", 18'h00200, 8'h20, 32'h0500_0000, 0);
        repeat (45) @(negedge clk);
        chk("t3 stall busy", 520'(busy), 520'(1));
        chk("t3 stall full", 520'(fifo_full), 520'(1));
        pop_check("t3 p0");
        chk("t3 push-on-pop busy", 520'(busy), 520'(0));
        chk("t3 push-on-pop full", 520'(fifo_full), 520'(1));
        for (int i = 1; i < 5; i++) pop_check($sformatf("t3 p%0d", i));
        chk("t3 drained", 520'(fifo_empty), 520'(1));

        // Pop in the exact PUSH cycle with one entry queued.
        start_fill("t4 a", 18'h0ABCD, 8'h33, 32'h7700_0000, 0);
        wait_idle("t4 a", 100);
        start_fill("t4 b", 18'h15555, 8'h34, 32'h8800_0000, 0);
        repeat (32) @(negedge clk);
        pop_check("t4 a");
        chk("t4 busy", 520'(busy), 520'(0));
        chk("t4 count1 empty", 520'(fifo_empty), 520'(0));
        chk("t4 count1 full", 520'(fifo_full), 520'(0));
        pop_check("t4 b");
        chk("t4 drained", 520'(fifo_empty), 520'(1));

        // Reset during WAIT of word 7, then a late valid and a fresh fill.
        mem_seed = 32'h3300_0000;
        mem_wait = 3;
        req_addr = 18'h00777;
        req_index = 8'h07;
        is_req = 1'b1;
        @(negedge clk);
        chk("t5 ack", 520'(req_ack), 520'(1));
        is_req = 1'b0;
        repeat (36) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("t5 busy", 520'(busy), 520'(0));
        chk("t5 empty", 520'(fifo_empty), 520'(1));
        chk("t5 mem_addr", 520'(mem_addr), 520'(0));
        repeat (4) @(negedge clk);
        chk("t5 stray busy", 520'(busy), 520'(0));
        chk("t5 stray empty", 520'(fifo_empty), 520'(1));
        chk("t5 stray rd_en", 520'(mem_rd_en), 520'(0));
        start_fill("t5 new", 18'h2AAAA, 8'h00, 32'h4400_0000, 1);
        wait_idle("t5 new", 200);
        pop_check("t5 new");

        // is_req held through the fill: exactly one extra fill.
        c0 = ack_cnt;
        mem_seed = 32'h5500_0000;
        mem_wait = 0;
        req_addr = 18'h01111;
        req_index = 8'h9C;
        sb.push_back({8'h9C, build_line(18'h01111, 8'h9C, 32'h5500_0000)});
        sb.push_back({8'h9C, build_line(18'h01111, 8'h9C, 32'h5500_0000)});
        is_req = 1'b1;
        @(negedge clk);
        wait_idle("t6 first", 100);
        @(negedge clk);
        chk("t6 re-ack", 520'(req_ack), 520'(1));
        is_req = 1'b0;
        wait_idle("t6 second", 100);
        repeat (5) @(negedge clk);
        chk("t6 held fills", 520'(ack_cnt - c0), 520'(2));
        pop_check("t6 a");
        pop_check("t6 b");
        chk("t6 drained", 520'(fifo_empty), 520'(1));

        // is_req dropped after req_ack: exactly one fill.
        c0 = ack_cnt;
        start_fill("t6 single", 18'h02222, 8'h9D, 32'h6600_0000, 0);
        wait_idle("t6 single", 100);
        repeat (5) @(negedge clk);
        chk("t6 single fills", 520'(ack_cnt - c0), 520'(1));
        pop_check("t6 single");
        chk("t6 single drained", 520'(fifo_empty), 520'(1));
        chk("sb empty", 520'(sb.size()), 520'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
